multdiv_iterative: RTL and testbench
====================================

Name: multdiv_iterative

Overview:
- Responder side of the processor's mult/div start/ready handshake.
- Accepts a one-cycle ctrl_MULT or ctrl_DIV start pulse with two 32-bit operands, and computes a signed multiply or divide iteratively.
- Reports result, exception and a one-cycle data_resultRDY pulse. in_progress stays high while the operation runs, so the initiator can hold its operand latches closed.
- Sits in the execute stage beside the ALU.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported.
- CNT_W, 6, iteration counter width.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- data_operandA  input  32  multiplicand / dividend; sampled only on the start edge.
- data_operandB  input  32  multiplier / divisor; sampled only on the start edge.
- ctrl_MULT  input  1  start signed multiply. One-cycle pulse.
- ctrl_DIV  input  1  start signed divide. One-cycle pulse.
- data_result  output  32  product low word or quotient. Held until the next start.
- data_exception  output  1  overflow or divide-by-zero. Held with data_result.
- data_resultRDY  output  1  high for exactly one cycle when the result is valid.
- in_progress  output  1  high while in MUL_RUN or DIV_RUN.

Behaviour:
- Reset (synchronous, active-high): state IDLE, counter 0, all outputs 0. Reset mid-operation aborts the operation; no RDY pulse is produced.
- States: IDLE, MUL_RUN, DIV_RUN, DONE. Encoding is 2-bit; in_progress and data_resultRDY decode directly from state.
- Start acceptance:
  - A start is accepted only in IDLE or DONE.
  - Starts in MUL_RUN or DIV_RUN are ignored; operands and the counter are unchanged.
  - If ctrl_MULT and ctrl_DIV are high together, the multiply wins.
- Start edge k: latch the operands; store |A|, |B| and the result sign (A[31]^B[31]); clear the counter. Next state is MUL_RUN or DIV_RUN.
- Divide by zero: if ctrl_DIV is accepted with B==0, the next state is DONE directly. data_result=0, data_exception=1, data_resultRDY high in the cycle after edge k.
- MUL_RUN: one unsigned shift-add step per edge, edges k+1..k+32, over a 64-bit accumulator.
- DIV_RUN: one unsigned restoring shift-subtract step per edge, edges k+1..k+32. Quotient magnitude is built in the low register, remainder in the high register.
- At edge k+32, counter==31 → the next state is DONE. The same edge applies sign correction and writes data_result/data_exception.
- Latency: data_resultRDY is high in the cycle following edge k+32, i.e. 32 cycles after the start edge. It drops after one cycle unless a new start is accepted on that edge; the DONE→RUN transition clears it.
- Multiply arithmetic:
  - data_result = low 32 bits of the signed 64-bit product.
  - data_exception = 1 when product[63:31] is not all-equal.
  - A zero operand yields product 0, exception 0, regardless of sign.
- Divide arithmetic:
  - Quotient truncates toward zero; the remainder is discarded.
  - 0x80000000 / 0xFFFFFFFF → data_result=0x80000000, data_exception=1.
- Hold rule: data_result and data_exception stay constant from DONE until the next accepted start. They then remain at the old value until the new completion.
- in_progress is 0 in IDLE and DONE, and 1 from the cycle after edge k through the cycle ending at edge k+32.
- Operand inputs may change freely after the start edge.

Decomposition:
- Shared package multdiv_pkg:
  - state encodings ST_IDLE=0, ST_MUL=1, ST_DIV=2, ST_DONE=3.
  - WIDTH=32, ITER_LAST=31, INT_MIN=32'h80000000.
- One combinational sub-module, multdiv_step:
  - inputs: 64-bit accumulator, 32-bit |B|, and a mode bit.
  - output: the next accumulator value for one shift-add (mul) or one shift-subtract-restore (div) iteration.
- The top module holds the FSM, counter, sign/abs logic and output registers.

Test Plan:
- MULT, A=7, B=0xFFFFFFFD (−3) → in_progress high 32 cycles; RDY one cycle, 32 cycles after the start edge; result 0xFFFFFFEB, exception 0.
- MULT, A=0x00010000, B=0x00010000 → result 0x00000000, exception 1. Then MULT A=0x7FFFFFFF, B=1 → result 0x7FFFFFFF, exception 0.
- DIV, A=0xFFFFFFF9 (−7), B=2 → result 0xFFFFFFFD, exception 0. Then DIV A=100, B=7 → result 14.
- DIV, A=5, B=0 → RDY in the cycle after the start edge, result 0, exception 1, in_progress never high. Then DIV 0x80000000/0xFFFFFFFF → result 0x80000000, exception 1.
- Start MULT 3×4, pulse ctrl_DIV at cycle 10 and ctrl_MULT at cycle 20 → both ignored; RDY still at 32 cycles with result 12. A start accepted in the RDY cycle begins a new op, and RDY drops.
- Start DIV 1000/10, assert reset at cycle 15 → outputs 0 next cycle, no RDY pulse. MULT 2×3 with simultaneous ctrl_DIV → result 6.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared encodings and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned CNT_W     = 6;
   localparam int unsigned ITER_LAST = 31;
   localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/multdiv_step.sv
// One unsigned iteration: shift-add for multiply, restoring shift-subtract for divide.
module multdiv_step
   import multdiv_pkg::*;
(
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_babs,
   input  logic               i_div,
   output logic [2*WIDTH-1:0] o_acc_c
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
   assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_babs};

   // Divide: acc = {remainder, dividend/quotient}; the trial remainder is acc[63:31].
   // When it is >= divisor the true difference is below 2^32, so 32-bit wrap is exact.
   assign w_ge   = i_acc[2*WIDTH-1] | (i_acc[2*WIDTH-2:WIDTH-1] >= i_babs);
   assign w_diff = i_acc[2*WIDTH-2:WIDTH-1] - i_babs;

   always_comb begin
      o_acc_c = i_acc;
      if (i_div) begin
         if (w_ge) o_acc_c = {w_diff, i_acc[WIDTH-2:0], 1'b1};
         else      o_acc_c = {i_acc[2*WIDTH-2:0], 1'b0};
      end else begin
         if (i_acc[0]) o_acc_c = {w_sum, i_acc[WIDTH-1:1]};
         else          o_acc_c = {1'b0, i_acc[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/multdiv_iterative.sv
// Iterative signed 32-bit multiply/divide responder: start pulse in, 32 steps, one-cycle RDY out.
module multdiv_iterative
   import multdiv_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             in_progress
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_babs;
   logic               r_sign;
   logic [WIDTH-1:0]   r_result;
   logic               r_exc;

   logic               w_accept;
   logic               w_start_mul;
   logic               w_start_div;
   logic               w_div0;
   logic               w_run;
   logic               w_last;
   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_fin_res;
   logic               w_fin_exc;

   // Starts are only honoured when no operation is running; multiply has priority.
   assign w_accept    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && (ctrl_MULT || ctrl_DIV);
   assign w_start_mul = w_accept & ctrl_MULT;
   assign w_start_div = w_accept & ~ctrl_MULT & ctrl_DIV;
   assign w_div0      = w_start_div & (data_operandB == '0);
   assign w_run       = (r_state == ST_MUL) || (r_state == ST_DIV);
   assign w_last      = w_run && (r_cnt == CNT_W'(ITER_LAST));

   // |INT_MIN| wraps to 0x80000000, which is the correct unsigned magnitude.
   assign w_a_abs = data_operandA[WIDTH-1] ? WIDTH'(-data_operandA) : data_operandA;
   assign w_b_abs = data_operandB[WIDTH-1] ? WIDTH'(-data_operandB) : data_operandB;

   multdiv_step u_step (
      .i_acc   (r_acc),
      .i_babs  (r_babs),
      .i_div   (r_state == ST_DIV),
      .o_acc_c (w_acc_nxt)
   );

   // Sign correction applied to the value produced by the final iteration.
   assign w_prod = r_sign ? (2*WIDTH)'(-w_acc_nxt) : w_acc_nxt;
   assign w_quot = r_sign ? WIDTH'(-w_acc_nxt[WIDTH-1:0]) : w_acc_nxt[WIDTH-1:0];

   always_comb begin
      w_fin_res = w_prod[WIDTH-1:0];
      w_fin_exc = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
      if (r_state == ST_DIV) begin
         w_fin_res = w_quot;
         // Only INT_MIN / -1 yields a positive magnitude of 2^31.
         w_fin_exc = ~r_sign & w_acc_nxt[WIDTH-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (r_state == ST_DONE) w_state_nxt = ST_IDLE;
            if (w_start_mul)        w_state_nxt = ST_MUL;
            else if (w_div0)        w_state_nxt = ST_DONE;
            else if (w_start_div)   w_state_nxt = ST_DIV;
         end
         ST_MUL, ST_DIV: begin
            if (w_last) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, and held result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_babs   <= '0;
         r_sign   <= 1'b0;
         r_result <= '0;
         r_exc    <= 1'b0;
      end else if (w_start_mul || w_start_div) begin
         r_cnt  <= '0;
         r_acc  <= {{WIDTH{1'b0}}, w_a_abs};
         r_babs <= w_b_abs;
         r_sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         if (w_div0) begin
            r_result <= '0;
            r_exc    <= 1'b1;
         end
      end else if (w_run) begin
         r_cnt <= r_cnt + CNT_W'(1);
         r_acc <= w_acc_nxt;
         if (w_last) begin
            r_result <= w_fin_res;
            r_exc    <= w_fin_exc;
         end
      end
   end

   assign data_result    = r_result;
   assign data_exception = r_exc;
   assign data_resultRDY = (r_state == ST_DONE);
   assign in_progress    = w_run;

endmodule

// File: tb/tb_multdiv_iterative.sv
// Directed-vector bench for multdiv_iterative with hand-computed expectations.
module tb_multdiv_iterative;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        in_progress;

   int n_vec  = 0;
   int n_miss = 0;

   multdiv_iterative dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .in_progress    (in_progress)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present a start for one edge, then scramble operands to prove they are latched.
   task automatic kick(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT = mul;
      ctrl_DIV = div;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic exp_exc,
                            input int exp_lat, input int exp_ip, input bit poke);
      int lat;
      int ip;
      lat = 0;
      ip = 0;
      while (!data_resultRDY && lat < 100) begin
         if (in_progress) ip++;
         if (poke && lat == 10) begin ctrl_DIV = 1'b1; data_operandA = 32'd55; data_operandB = 32'd0; end
         if (poke && lat == 20) begin ctrl_MULT = 1'b1; data_operandA = 32'd99; data_operandB = 32'd99; end
         @(posedge clock); #1;
         ctrl_MULT = 1'b0;
         ctrl_DIV = 1'b0;
         lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".ip"},  32'(ip),  32'(exp_ip));
      check({tag, ".res"}, data_result, exp_res);
      check({tag, ".exc"}, 32'(data_exception), 32'(exp_exc));
   endtask

   task automatic check_drop(input string tag, input logic [31:0] exp_res, input logic exp_exc);
      @(posedge clock); #1;
      check({tag, ".rdy_drop"}, 32'(data_resultRDY), 32'd0);
      check({tag, ".ip_idle"},  32'(in_progress),    32'd0);
      check({tag, ".hold_res"}, data_result, exp_res);
      check({tag, ".hold_exc"}, 32'(data_exception), 32'(exp_exc));
   endtask

   initial begin
      int rdy_seen;
      reset = 1'b1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst.res", data_result, 32'd0);
      check("rst.exc", 32'(data_exception), 32'd0);
      check("rst.rdy", 32'(data_resultRDY), 32'd0);
      check("rst.ip",  32'(in_progress), 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      kick(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      wait_done("mul_7xm3", 32'hFFFF_FFEB, 1'b0, 32, 32, 1'b0);
      check_drop("mul_7xm3", 32'hFFFF_FFEB, 1'b0);

      kick(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
      wait_done("mul_ovf", 32'h0000_0000, 1'b1, 32, 32, 1'b0);
      check_drop("mul_ovf", 32'h0000_0000, 1'b1);

      kick(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1);
      wait_done("mul_max", 32'h7FFF_FFFF, 1'b0, 32, 32, 1'b0);

      kick(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_m7d2", 32'hFFFF_FFFD, 1'b0, 32, 32, 1'b0);
      check_drop("div_m7d2", 32'hFFFF_FFFD, 1'b0);

      kick(1'b0, 1'b1, 32'd100, 32'd7);
      wait_done("div_100d7", 32'd14, 1'b0, 32, 32, 1'b0);

      kick(1'b0, 1'b1, 32'd5, 32'd0);
      check("div0.ip_first", 32'(in_progress), 32'd0);
      wait_done("div0", 32'd0, 1'b1, 0, 0, 1'b0);
      check_drop("div0", 32'd0, 1'b1);

      kick(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_min", 32'h8000_0000, 1'b1, 32, 32, 1'b0);

      kick(1'b1, 1'b0, 32'd3, 32'd4);
      wait_done("mul_ign", 32'd12, 1'b0, 32, 32, 1'b1);
      // Back-to-back start in the RDY cycle.
      kick(1'b1, 1'b0, 32'd5, 32'd6);
      check("b2b.rdy_drop", 32'(data_resultRDY), 32'd0);
      check("b2b.ip",       32'(in_progress), 32'd1);
      check("b2b.hold_res", data_result, 32'd12);
      wait_done("b2b", 32'd30, 1'b0, 32, 32, 1'b0);
      check_drop("b2b", 32'd30, 1'b0);

      kick(1'b0, 1'b1, 32'd1000, 32'd10);
      repeat (14) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("rst_mid.res", data_result, 32'd0);
      check("rst_mid.exc", 32'(data_exception), 32'd0);
      check("rst_mid.rdy", 32'(data_resultRDY), 32'd0);
      check("rst_mid.ip",  32'(in_progress), 32'd0);
      rdy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (data_resultRDY) rdy_seen++;
         @(posedge clock); #1;
      end
      check("rst_mid.no_rdy", 32'(rdy_seen), 32'd0);

      kick(1'b1, 1'b1, 32'd2, 32'd3);
      wait_done("mul_prio", 32'd6, 1'b0, 32, 32, 1'b0);
      check_drop("mul_prio", 32'd6, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
